// File: rtl/pdm_decimator_if.sv
// Output-side handshake bundle of the PDM decimator: sample, valid/ready and sticky overrun.
interface pdm_decimator_if #(
    parameter int DATA_BITS = 12
);
    logic [DATA_BITS-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 overrun;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready,
        output overrun
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready,
        input  overrun
    );
endinterface

// File: rtl/pdm_decimator.sv
// Boxcar (first-order CIC) decimator: counts ones over windows of 2**DATA_BITS accepted
// PDM bits and offers each count through a one-entry valid/ready output register.
module pdm_decimator #(
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pdm_in,
    input  logic            sample_en,
    pdm_decimator_if.master bus
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DATA_BITS-1:0]   bit_cnt_r;
    logic [DATA_BITS:0]     ones_cnt_r;
    logic [DATA_BITS-1:0]   dout_r;
    logic                   dout_valid_r;
    logic                   overrun_r;

    logic                   bit_s;
    logic                   close_s;
    logic [DATA_BITS:0]     total_s;

    // A full window of ones gives exactly 2**DATA_BITS, the only value with the MSB set.
    function automatic logic [DATA_BITS-1:0] saturate(input logic [DATA_BITS:0] total);
        logic [DATA_BITS-1:0] result;
        if (total[DATA_BITS]) begin
            result = {DATA_BITS{1'b1}};
        end else begin
            result = total[DATA_BITS-1:0];
        end
        return result;
    endfunction

    assign bit_s   = sync_r[SYNC_STAGES-1];
    assign close_s = sample_en && (bit_cnt_r == {DATA_BITS{1'b1}});
    assign total_s = ones_cnt_r + {{DATA_BITS{1'b0}}, bit_s};

    // Synchroniser chain for the possibly asynchronous PDM input, clocked every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r[0] <= pdm_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Window counters: advance only on accepted bits, so gaps stretch the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= {DATA_BITS{1'b0}};
            ones_cnt_r <= {(DATA_BITS+1){1'b0}};
        end else if (sample_en) begin
            bit_cnt_r <= bit_cnt_r + DATA_BITS'(1);
            if (close_s) begin
                ones_cnt_r <= {(DATA_BITS+1){1'b0}};
            end else begin
                ones_cnt_r <= total_s;
            end
        end else begin
            bit_cnt_r  <= bit_cnt_r;
            ones_cnt_r <= ones_cnt_r;
        end
    end

    // One-entry output register; a close always wins, overwriting an unconsumed sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_r       <= {DATA_BITS{1'b0}};
            dout_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (close_s) begin
            dout_r       <= saturate(total_s);
            dout_valid_r <= 1'b1;
            if (dout_valid_r && !bus.dout_ready) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (dout_valid_r && bus.dout_ready) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator (DATA_BITS=4, SYNC_STAGES=2) against a window-list model.
module tb_pdm_decimator;
    localparam int DB  = 4;
    localparam int WIN = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pdm_in = 1'b0;
    logic sample_en = 1'b0;

    pdm_decimator_if #(.DATA_BITS(DB)) bus_if ();

    pdm_decimator #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_in    (pdm_in),
        .sample_en (sample_en),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bits seen at the last two edges, accepted bits of the open window, output state.
    bit       pdm_d1 = 1'b0;
    bit       pdm_d2 = 1'b0;
    bit       win[$];
    bit [3:0] m_dout = 4'd0;
    bit       m_valid = 1'b0;
    bit       m_ovr = 1'b0;
    int       mod_acc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dout"}, int'(bus_if.dout), int'(m_dout));
        check({tag, ".valid"}, int'(bus_if.dout_valid), int'(m_valid));
        check({tag, ".overrun"}, int'(bus_if.overrun), int'(m_ovr));
    endtask

    function automatic void model_reset();
        pdm_d1 = 1'b0;
        pdm_d2 = 1'b0;
        win.delete();
        m_dout = 4'd0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
    endfunction

    // Drive one clock's worth of inputs, advance the model across the edge, then compare.
    task automatic cycle(input bit pdm, input bit en, input bit rdy, input string tag);
        int  sum;
        bit  closing;
        pdm_in = pdm;
        sample_en = en;
        bus_if.dout_ready = rdy;
        closing = 1'b0;
        if (en) begin
            win.push_back(pdm_d2);
            if (win.size() == WIN) closing = 1'b1;
        end
        if (closing) begin
            sum = 0;
            foreach (win[i]) sum += int'(win[i]);
            if (m_valid && !rdy) m_ovr = 1'b1;
            m_dout = (sum > 15) ? 4'd15 : 4'(sum);
            m_valid = 1'b1;
            win.delete();
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        pdm_d2 = pdm_d1;
        pdm_d1 = pdm;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic bit modulate5();
        mod_acc += 5;
        if (mod_acc >= WIN) begin
            mod_acc -= WIN;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        mod_acc = 0;
    endtask

    initial begin
        int cnt;
        bus_if.dout_ready = 1'b0;

        // Reset held from time zero; outputs must be cleared.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // All-zero stream, always ready.
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, "zeros");

        // All-one stream saturates to 15.
        do_reset("rst_ones");
        for (int i = 0; i < 50; i++) cycle(1'b1, 1'b1, 1'b1, "ones");
        check("ones.sat_dout", int'(bus_if.dout), 15);

        // First-order modulator at density 5/16.
        do_reset("rst_mod");
        for (int i = 0; i < 100; i++) cycle(modulate5(), 1'b1, 1'b1, "mod5");
        check("mod5.dout", int'(bus_if.dout), 5);

        // Modulator gated to every third clock.
        do_reset("rst_gate");
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            bit en;
            en = (i % 3 == 0);
            cycle(en ? modulate5() : pdm_d1, en, 1'b1, "gated");
        end
        check("gated.dout", int'(bus_if.dout), 5);

        // Consumer stalls across two closes, then accepts on a later close.
        do_reset("rst_ovr");
        for (int i = 0; i < 2 * WIN + 2; i++) cycle(modulate5(), 1'b1, 1'b0, "stall");
        check("stall.overrun", int'(bus_if.overrun), 1);
        cnt = 0;
        while (win.size() != WIN - 1 && cnt < 40) begin
            cycle(modulate5(), 1'b1, 1'b0, "stall2");
            cnt++;
        end
        cycle(modulate5(), 1'b1, 1'b1, "ready_on_close");
        check("ready_on_close.valid", int'(bus_if.dout_valid), 1);

        // Reset in the middle of a window while a sample is pending.
        cnt = 0;
        while (!(m_valid && win.size() == 9) && cnt < 60) begin
            cycle($urandom_range(0, 1), 1'b1, 1'b0, "pre_mid_rst");
            cnt++;
        end
        check("pre_mid_rst.valid", int'(bus_if.dout_valid), 1);
        do_reset("mid_rst");
        for (int i = 0; i < 20; i++) cycle($urandom_range(0, 1), 1'b1, 1'b0, "post_rst");

        // Randomized density, strobe and ready.
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = $urandom_range(0, 16);
            for (int i = 0; i < 300; i++) begin
                cycle(($urandom_range(0, 15) < dens), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) != 0), "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
